tdm_mux8: RTL and testbench

TDM_MUX8 -- requirements
Module: tdm_mux8

---
 rtl/tdm_mux8_pkg.sv | 25 ++
 rtl/tdm_slot_cnt.sv | 77 +++++++
 rtl/tdm_mux8.sv | 114 +++++++++++
 tb/tb_tdm_mux8.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux8_pkg.sv
// ---------------------------------------------------------------------------
// tdm_mux8_pkg
//   Shared definitions for the 8-slot TDM multiplexer:
//     - state_e     : FSM state encoding (IDLE / SEND)
//     - SLOT_W      : width of the slot index (sel)
//     - NSLOT       : number of slots per frame
//     - hold_cnt_w  : width of the per-slot hold counter for a given HOLD
// ---------------------------------------------------------------------------
package tdm_mux8_pkg;

  localparam int SLOT_W = 3;
  localparam int NSLOT  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Width of a counter that runs 0..hold-1; never narrower than one bit so
  // that HOLD=1 still yields a legal vector.
  function automatic int hold_cnt_w(input int hold);
    return (hold <= 1) ? 1 : $clog2(hold);
  endfunction

endpackage : tdm_mux8_pkg

// File: rtl/tdm_slot_cnt.sv
// ---------------------------------------------------------------------------
// tdm_slot_cnt
//   Hold counter plus slot counter. The hold counter runs 0..HOLD-1; each
//   time it wraps, the slot index advances by one. 'last' flags the final
//   cycle of the final slot of a frame.
//
//   Ports
//     clk    : clock, rising edge
//     rst    : asynchronous active-high reset
//     clear  : synchronous return of both counters to zero (has priority)
//     enable : advance the counters this cycle
//     sel    : current slot index
//     last   : slot == LAST_SLOT and hold counter == HOLD-1
// ---------------------------------------------------------------------------
module tdm_slot_cnt
  import tdm_mux8_pkg::*;
#(
  parameter int              HOLD      = 1,
  parameter logic [SLOT_W-1:0] LAST_SLOT = 3'd7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  output logic [SLOT_W-1:0] sel,
  output logic              last
);

  localparam int            CW      = hold_cnt_w(HOLD);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD - 1);

  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [SLOT_W-1:0] sel_q;
  logic [SLOT_W-1:0] sel_d;
  logic              wrap_s;

  assign wrap_s = (cnt_q == CNT_MAX);

  // Next-state logic for the hold and slot counters.
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (clear) begin
      cnt_d = '0;
      sel_d = '0;
    end else if (enable) begin
      if (wrap_s) begin
        // The slot index only advances here; the owner clears on 'last',
        // so the 7->0 roll-over never happens through this path.
        cnt_d = '0;
        sel_d = sel_q + 3'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        sel_d = sel_q;
      end
    end else begin
      cnt_d = cnt_q;
      sel_d = sel_q;
    end
  end

  // Counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  assign sel  = sel_q;
  assign last = wrap_s && (sel_q == LAST_SLOT);

endmodule : tdm_slot_cnt

// File: rtl/tdm_mux8.sv
// ---------------------------------------------------------------------------
// tdm_mux8
//   Time-division multiplexer: on a start request, the 8-bit parallel input
//   is captured into a shadow register and shifted out one slot at a time on
//   y, each slot held for HOLD cycles. A start in the frame's final cycle
//   chains a new frame with no gap.
//
//   Ports
//     clk        : clock, rising edge
//     rst        : asynchronous active-high reset
//     start      : request one frame (sampled on clk edges)
//     d[7:0]     : slot data, d[i] goes out in slot i
//     y          : serial TDM line (shadow[sel] while valid, else 0)
//     sel[2:0]   : current slot index
//     valid      : high while a frame is being sent
//     busy       : identical to valid
//     frame_done : one-cycle pulse in the last cycle of a frame
//
//   All outputs are decoded from registers only; start and d reach no
//   output combinationally.
// ---------------------------------------------------------------------------
module tdm_mux8
  import tdm_mux8_pkg::*;
#(
  parameter int HOLD  = 1,
  parameter int NSLOT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        d,
  output logic              y,
  output logic [SLOT_W-1:0] sel,
  output logic              valid,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);

  state_e            state_q;
  logic [7:0]        shadow_q;
  logic [SLOT_W-1:0] sel_s;
  logic              last_s;
  logic              send_s;
  logic              cnt_clear_s;
  logic              cnt_en_s;

  assign send_s = (state_q == SEND);

  // Counters sit at zero in IDLE; they are also zeroed on the final cycle
  // so that an idle return or a chained frame both start from slot 0.
  assign cnt_clear_s = !send_s || last_s;
  assign cnt_en_s    = send_s;

  tdm_slot_cnt #(
    .HOLD      (HOLD),
    .LAST_SLOT (LAST_SLOT)
  ) u_slot_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear_s),
    .enable (cnt_en_s),
    .sel    (sel_s),
    .last   (last_s)
  );

  // Frame FSM and shadow capture; start is honoured only in IDLE or in the
  // final cycle of a frame, otherwise it is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= SEND;
            shadow_q <= d;
          end else begin
            state_q  <= IDLE;
            shadow_q <= shadow_q;
          end
        end
        SEND: begin
          if (last_s) begin
            if (start) begin
              state_q  <= SEND;
              shadow_q <= d;
            end else begin
              state_q  <= IDLE;
              shadow_q <= shadow_q;
            end
          end else begin
            state_q  <= SEND;
            shadow_q <= shadow_q;
          end
        end
        default: begin
          state_q  <= IDLE;
          shadow_q <= 8'h00;
        end
      endcase
    end
  end

  // Output decode: everything is forced low outside SEND.
  assign valid      = send_s;
  assign busy       = send_s;
  assign sel        = send_s ? sel_s : 3'd0;
  assign y          = send_s & shadow_q[sel_s];
  assign frame_done = send_s & last_s;

endmodule : tdm_mux8

// File: tb/tb_tdm_mux8.sv
// ---------------------------------------------------------------------------
// tb_tdm_mux8
//   Directed bench for tdm_mux8 with two instances (HOLD=1 and HOLD=3).
//   Expected per-cycle outputs are queued when a frame is requested and
//   popped/compared one cycle at a time; an empty queue means IDLE outputs.
// ---------------------------------------------------------------------------
module tb_tdm_mux8;

  typedef struct packed {
    logic       y;
    logic [2:0] sel;
    logic       valid;
    logic       busy;
    logic       fd;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start1;
  logic [7:0] d1;
  logic       y1;
  logic [2:0] sel1;
  logic       valid1;
  logic       busy1;
  logic       fd1;
  logic       start3;
  logic [7:0] d3;
  logic       y3;
  logic [2:0] sel3;
  logic       valid3;
  logic       busy3;
  logic       fd3;

  int checks = 0;
  int errors = 0;

  exp_t q1[$];
  exp_t q3[$];

  tdm_mux8 #(.HOLD(1), .NSLOT(8)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .d          (d1),
    .y          (y1),
    .sel        (sel1),
    .valid      (valid1),
    .busy       (busy1),
    .frame_done (fd1)
  );

  tdm_mux8 #(.HOLD(3), .NSLOT(8)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .start      (start3),
    .d          (d3),
    .y          (y3),
    .sel        (sel3),
    .valid      (valid3),
    .busy       (busy3),
    .frame_done (fd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input exp_t obs, input exp_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (y,sel,valid,busy,fd)", tag, obs, exp);
    end
  endtask

  // Queue the expected outputs of one full frame for instance 1 or 3.
  task automatic push_frame(input int inst, input logic [7:0] data);
    int   hold;
    exp_t e;
    hold = (inst == 1) ? 1 : 3;
    for (int s = 0; s < 8; s++) begin
      for (int h = 0; h < hold; h++) begin
        e.y     = data[s];
        e.sel   = 3'(s);
        e.valid = 1'b1;
        e.busy  = 1'b1;
        e.fd    = (s == 7) && (h == hold - 1);
        if (inst == 1) q1.push_back(e);
        else           q3.push_back(e);
      end
    end
  endtask

  // Advance one clock and compare both instances against the scoreboard.
  task automatic cycle(input string tag);
    exp_t e1;
    exp_t e3;
    @(posedge clk);
    #1;
    e1 = (q1.size() > 0) ? q1.pop_front() : exp_t'(7'd0);
    e3 = (q3.size() > 0) ? q3.pop_front() : exp_t'(7'd0);
    chk({tag, "/h1"}, {y1, sel1, valid1, busy1, fd1}, e1);
    chk({tag, "/h3"}, {y3, sel3, valid3, busy3, fd3}, e3);
  endtask

  initial begin
    rst    = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    d1     = 8'h00;
    d3     = 8'h00;

    // Reset state, including start held high during reset.
    chk("reset_async", {y1, sel1, valid1, busy1, fd1}, exp_t'(7'd0));
    start1 = 1'b1;
    d1     = 8'hFF;
    cycle("reset_hold");
    start1 = 1'b0;
    rst    = 1'b0;
    cycle("post_reset_idle");

    // HOLD=1 single frame, d=1010_0110.
    d1     = 8'b1010_0110;
    start1 = 1'b1;
    push_frame(1, 8'b1010_0110);
    cycle("f1_s0");
    start1 = 1'b0;
    for (int i = 0; i < 7; i++) cycle("f1_body");
    cycle("f1_idle");

    // HOLD=3, d=FF.
    d3     = 8'hFF;
    start3 = 1'b1;
    push_frame(3, 8'hFF);
    cycle("h3_s0");
    start3 = 1'b0;
    d3     = 8'h00;
    for (int i = 0; i < 23; i++) cycle("h3_body");
    cycle("h3_idle");

    // Back-to-back frames with start held high: 01 then 80.
    d1     = 8'h01;
    start1 = 1'b1;
    push_frame(1, 8'h01);
    cycle("b2b_a_s0");
    d1 = 8'h80;
    for (int i = 0; i < 7; i++) cycle("b2b_a_body");
    push_frame(1, 8'h80);
    cycle("b2b_b_s0");
    start1 = 1'b0;
    for (int i = 0; i < 7; i++) cycle("b2b_b_body");
    cycle("b2b_idle");

    // Capture F0, then change d to 00 at sel=3.
    d1     = 8'hF0;
    start1 = 1'b1;
    push_frame(1, 8'hF0);
    cycle("shadow_s0");
    start1 = 1'b0;
    for (int i = 0; i < 3; i++) cycle("shadow_pre");
    d1 = 8'h00;
    for (int i = 0; i < 4; i++) cycle("shadow_post");
    cycle("shadow_idle");

    // Start pulsed at sel=2 is ignored.
    d1     = 8'h5A;
    start1 = 1'b1;
    push_frame(1, 8'h5A);
    cycle("ign_s0");
    start1 = 1'b0;
    cycle("ign_s1");
    cycle("ign_s2");
    d1     = 8'hC3;
    start1 = 1'b1;
    cycle("ign_s3");
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) cycle("ign_body");
    cycle("ign_idle");
    cycle("ign_idle2");

    // Reset asserted mid-frame at sel=5, between clock edges.
    d1     = 8'hFF;
    start1 = 1'b1;
    push_frame(1, 8'hFF);
    cycle("rst_s0");
    start1 = 1'b0;
    for (int i = 0; i < 5; i++) cycle("rst_pre");
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_async", {y1, sel1, valid1, busy1, fd1}, exp_t'(7'd0));
    q1.delete();
    cycle("rst_mid_hold");
    rst = 1'b0;
    cycle("rst_release_idle");
    cycle("rst_release_idle2");

    // Clean frame after reset release.
    d1     = 8'h96;
    start1 = 1'b1;
    push_frame(1, 8'h96);
    cycle("after_rst_s0");
    start1 = 1'b0;
    for (int i = 0; i < 7; i++) cycle("after_rst_body");
    cycle("after_rst_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_tdm_mux8
